// File: rtl/osc_stim_gen_if.sv
// osc_stim_gen_if: control/status bundle for the square-wave burst generator.
// master = block that requests bursts, slave = the generator itself.
interface osc_stim_gen_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
);
    logic             start;
    logic [DIV_W-1:0] half_period;
    logic [CNT_W-1:0] num_edges;
    logic             abort;
    logic             osc_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] edges_sent;

    modport master (
        output start, half_period, num_edges, abort,
        input  osc_out, busy, done, edges_sent
    );

    modport slave (
        input  start, half_period, num_edges, abort,
        output osc_out, busy, done, edges_sent
    );
endinterface

// File: rtl/osc_stim_gen.sv
// osc_stim_gen: programmable square-wave burst generator. Emits N rising edges
// with a 50% duty cycle and a period of 2*H clk cycles on osc_out.
// Optional build macro OSC_STIM_FREE_RUN_EN: a start with num_edges==0 runs
// indefinitely (until abort/rst) instead of completing immediately.
module osc_stim_gen #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    osc_stim_gen_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic [DIV_W-1:0] h_r, h_s;
    logic [CNT_W-1:0] n_r, n_s;
    logic [CNT_W-1:0] edges_r, edges_s;
    logic             osc_r, osc_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [DIV_W-1:0] h_eff_s;
    logic             burst_end_s;
    logic             run_s;
`ifdef OSC_STIM_FREE_RUN_EN
    logic             free_r, free_s;
`endif

    // A zero half-period would stall the divider; it is run as one cycle.
    assign h_eff_s = (bus.half_period == DIV_ZERO) ? DIV_ONE : bus.half_period;

    // Accepting a start in IDLE either launches a burst or, for N==0 in the
    // default build, completes at once. The last HIGH phase ends the burst
    // unless the generator is free-running.
`ifdef OSC_STIM_FREE_RUN_EN
    assign run_s       = 1'b1;
    assign burst_end_s = (!free_r) && (edges_r == n_r);
`else
    assign run_s       = (bus.num_edges != CNT_ZERO);
    assign burst_end_s = (edges_r == n_r);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: abort has priority over a phase ending.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = run_s ? ST_LOW : ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else if (div_r == DIV_ZERO) begin
                    state_s = ST_HIGH;
                end else begin
                    state_s = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else if (div_r == DIV_ZERO) begin
                    state_s = burst_end_s ? ST_DONE : ST_LOW;
                end else begin
                    state_s = ST_HIGH;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values, derived from the upcoming state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        h_s     = h_r;
        n_s     = n_r;
        div_s   = div_r;
        edges_s = edges_r;
`ifdef OSC_STIM_FREE_RUN_EN
        free_s  = free_r;
`endif
        if ((state_r == ST_IDLE) && bus.start) begin
            h_s     = h_eff_s;
            n_s     = bus.num_edges;
            div_s   = h_eff_s - DIV_ONE;
            edges_s = CNT_ZERO;
`ifdef OSC_STIM_FREE_RUN_EN
            free_s  = (bus.num_edges == CNT_ZERO);
`endif
        end else if ((state_s != state_r) && ((state_s == ST_LOW) || (state_s == ST_HIGH))) begin
            // Reload on every phase entry so each phase lasts exactly H cycles.
            div_s = h_r - DIV_ONE;
        end else if ((div_r != DIV_ZERO) && ((state_r == ST_LOW) || (state_r == ST_HIGH))) begin
            div_s = div_r - DIV_ONE;
        end else begin
            div_s = div_r;
        end

        if ((state_r == ST_LOW) && (state_s == ST_HIGH)) begin
            edges_s = edges_r + CNT_ONE;
        end else begin
            edges_s = edges_s;
        end

        osc_s  = (state_s == ST_HIGH);
        busy_s = (state_s == ST_LOW) || (state_s == ST_HIGH);
        done_s = (state_s == ST_DONE);
    end

    // Divider, latched configuration and edge counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r   <= DIV_ZERO;
            h_r     <= DIV_ZERO;
            n_r     <= CNT_ZERO;
            edges_r <= CNT_ZERO;
`ifdef OSC_STIM_FREE_RUN_EN
            free_r  <= 1'b0;
`endif
        end else begin
            div_r   <= div_s;
            h_r     <= h_s;
            n_r     <= n_s;
            edges_r <= edges_s;
`ifdef OSC_STIM_FREE_RUN_EN
            free_r  <= free_s;
`endif
        end
    end

    // Registered, glitch-free outputs; only rst may change them asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            osc_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            osc_r  <= osc_s;
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    assign bus.osc_out    = osc_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.edges_sent = edges_r;
endmodule

// File: tb/tb_osc_stim_gen.sv
// tb_osc_stim_gen: directed bench for osc_stim_gen with a timing-formula model
// checked on every negative clock edge, plus hand-computed point checks.
module tb_osc_stim_gen;
    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     checks = 0;
    int     failures = 0;

    osc_stim_gen_if #(.DIV_W(16), .CNT_W(8)) bus ();

    osc_stim_gen #(.DIV_W(16), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model of the most recently accepted burst, described by its start cycle.
    int     m_valid = 0;
    longint m_t = 0;
    int     m_h = 1;
    int     m_n = 0;
    int     m_free = 0;
    int     m_prev_edges = 0;
    longint m_abort_rel = -1;

    function automatic void model_expect(input longint c, output logic e_osc,
                                         output logic e_busy, output logic e_done,
                                         output logic [7:0] e_edges);
        longint rel, p, len;
        e_osc = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_edges = 8'd0;
        if (m_valid == 0) return;
        rel = c - m_t;
        if (rel < 1) begin
            e_edges = 8'(m_prev_edges);
            return;
        end
        if (m_n == 0 && m_free == 0) begin
            e_done = (rel == 1);
            return;
        end
        if (m_abort_rel >= 0 && rel > m_abort_rel) begin
            p = (m_abort_rel - 1) / m_h;
            e_edges = 8'(((p + 1) / 2) % 256);
            return;
        end
        len = 2 * m_n * m_h;
        if (m_free != 0 || rel <= len) begin
            e_busy  = 1'b1;
            p       = (rel - 1) / m_h;
            e_osc   = ((p % 2) == 1);
            e_edges = 8'(((p + 1) / 2) % 256);
        end else begin
            e_edges = 8'(m_n);
            e_done  = (rel == len + 1);
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        logic eo, eb, ed;
        logic [7:0] ee;
        model_expect(cyc, eo, eb, ed, ee);
        chk("osc_out", {31'd0, bus.osc_out}, {31'd0, eo});
        chk("busy", {31'd0, bus.busy}, {31'd0, eb});
        chk("done", {31'd0, bus.done}, {31'd0, ed});
        chk("edges_sent", {24'd0, bus.edges_sent}, {24'd0, ee});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input longint c);
        while (cyc < c) tick();
    endtask

    // Drive start in the current cycle; the model accepts it only when idle.
    task automatic apply_start(input int h, input int n);
        logic eo, eb, ed;
        logic [7:0] ee;
        bus.start       = 1'b1;
        bus.half_period = 16'(h);
        bus.num_edges   = 8'(n);
        model_expect(cyc, eo, eb, ed, ee);
        if (!eb && !ed) begin
            m_prev_edges = int'(ee);
            m_valid      = 1;
            m_t          = cyc;
            m_h          = (h == 0) ? 1 : h;
            m_n          = n;
            m_abort_rel  = -1;
`ifdef OSC_STIM_FREE_RUN_EN
            m_free       = (n == 0) ? 1 : 0;
`else
            m_free       = 0;
`endif
        end
    endtask

    task automatic apply_abort;
        logic eo, eb, ed;
        logic [7:0] ee;
        bus.abort = 1'b1;
        model_expect(cyc, eo, eb, ed, ee);
        if (eb && m_abort_rel < 0) m_abort_rel = cyc - m_t;
    endtask

    task automatic at_neg(input longint c);
        go_to(c);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint t;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.half_period = 16'd0; bus.num_edges = 8'd0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_osc", {31'd0, bus.osc_out}, 32'd0);
        chk("reset_edges", {24'd0, bus.edges_sent}, 32'd0);

        // Nominal burst H=2, N=3.
        tick(); t = cyc; apply_start(2, 3); tick(); bus.start = 1'b0;
        at_neg(t + 2);  chk("nom_low_t2", {31'd0, bus.osc_out}, 32'd0);
        at_neg(t + 3);  chk("nom_rise_t3", {31'd0, bus.osc_out}, 32'd1);
        chk("nom_edges_t3", {24'd0, bus.edges_sent}, 32'd1);
        at_neg(t + 12); chk("nom_busy_t12", {31'd0, bus.busy}, 32'd1);
        chk("nom_edges_t12", {24'd0, bus.edges_sent}, 32'd3);
        at_neg(t + 13); chk("nom_done_t13", {31'd0, bus.done}, 32'd1);
        go_to(t + 16);

        // H==0 clamps to one cycle per phase.
        t = cyc; apply_start(0, 2); tick(); bus.start = 1'b0;
        at_neg(t + 2); chk("clamp_rise_t2", {31'd0, bus.osc_out}, 32'd1);
        at_neg(t + 3); chk("clamp_low_t3", {31'd0, bus.osc_out}, 32'd0);
        at_neg(t + 4); chk("clamp_rise_t4", {31'd0, bus.osc_out}, 32'd1);
        at_neg(t + 5); chk("clamp_done_t5", {31'd0, bus.done}, 32'd1);
        go_to(t + 8);

        // Abort on the cycle of the third rising edge (H=4, N=10).
        t = cyc; apply_start(4, 10); tick(); bus.start = 1'b0;
        go_to(t + 21); apply_abort(); tick(); bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_edges", {24'd0, bus.edges_sent}, 32'd3);
        go_to(t + 30);

        // Start and abort together in IDLE: start wins (H=1, N=1 -> done at T+3).
        t = cyc; apply_start(1, 1); apply_abort(); tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        at_neg(t + 3); chk("startabort_done", {31'd0, bus.done}, 32'd1);
        go_to(t + 6);

        // Start while busy is ignored (H=3, N=2, then H=1, N=5 mid-burst).
        t = cyc; apply_start(3, 2); tick(); bus.start = 1'b0;
        go_to(t + 5); apply_start(1, 5); tick(); bus.start = 1'b0;
        bus.half_period = 16'd7; bus.num_edges = 8'd9;
        at_neg(t + 13); chk("busy_start_done", {31'd0, bus.done}, 32'd1);
        chk("busy_start_edges", {24'd0, bus.edges_sent}, 32'd2);
        go_to(t + 16);

        // Asynchronous reset during HIGH, then a fresh burst.
        t = cyc; apply_start(2, 4); tick(); bus.start = 1'b0;
        go_to(t + 3);
        #2 rst = 1'b1; m_valid = 0; m_prev_edges = 0;
        #1;
        chk("rst_async_osc", {31'd0, bus.osc_out}, 32'd0);
        chk("rst_async_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_async_edges", {24'd0, bus.edges_sent}, 32'd0);
        tick(); tick(); rst = 1'b0;
        tick(); t = cyc; apply_start(1, 1); tick(); bus.start = 1'b0;
        at_neg(t + 2); chk("post_rst_rise", {31'd0, bus.osc_out}, 32'd1);
        at_neg(t + 3); chk("post_rst_done", {31'd0, bus.done}, 32'd1);
        go_to(t + 6);

        // N==0 behaviour depends on the build.
        t = cyc; apply_start(1, 0); tick(); bus.start = 1'b0;
`ifdef OSC_STIM_FREE_RUN_EN
        at_neg(t + 600);
        chk("free_edges_wrap", {24'd0, bus.edges_sent}, 32'd44);
        chk("free_busy", {31'd0, bus.busy}, 32'd1);
        go_to(t + 600); apply_abort(); tick(); bus.abort = 1'b0;
        @(negedge clk);
        chk("free_abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("free_abort_edges", {24'd0, bus.edges_sent}, 32'd44);
`else
        at_neg(t + 1);
        chk("n0_done_t1", {31'd0, bus.done}, 32'd1);
        chk("n0_busy_t1", {31'd0, bus.busy}, 32'd0);
        at_neg(t + 2); chk("n0_done_t2", {31'd0, bus.done}, 32'd0);
`endif
        go_to(cyc + 5);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
